// File: rtl/rpn_stack_fsm.sv
// RPN calculator controller: keypad codes drive a DEPTH-deep operand stack, ALU handshake and register file.
// Key strobes update state one cycle later; key=0 while an ALU/load/store operation is in flight drops strobes.
module rpn_stack_fsm #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int NREGS  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        tecla,
  input  logic              tecla_valid,
  input  logic [WIDTH-1:0]  calcresult,
  input  logic              overflow,
  input  logic              ready,
  input  logic [WIDTH-1:0]  regload,
  output logic [ADDR_W-1:0] regadress,
  output logic [WIDTH-1:0]  regstore,
  output logic              regwrite,
  output logic              alu_start,
  output logic              subtract,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic              ok,
  output logic              key
);

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, ENTRY, ALU_WAIT, LOAD_WAIT, ERR} state_t;

  state_t             state;
  logic               lift;
  logic [WIDTH-1:0]   stack [DEPTH];
  logic [WIDTH+3:0]   entry_val;
  logic               accept;
  logic               addr_bad;

  assign accept    = tecla_valid & key;
  assign entry_val = ({4'b0, stack[0]} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, tecla};
  assign addr_bad  = stack[0] >= WIDTH'(NREGS);

  assign ok = (state != ERR);
  assign A  = (state == ERR) ? MAXV : stack[1];
  assign B  = (state == ERR) ? MAXV : stack[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lift      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      regadress <= '0;
      regstore  <= '0;
      regwrite  <= 1'b0;
      alu_start <= 1'b0;
      subtract  <= 1'b0;
      key       <= 1'b1;
    end else begin
      regwrite  <= 1'b0;
      alu_start <= 1'b0;
      key       <= 1'b1;
      case (state)
        IDLE, ENTRY: begin
          if (accept) begin
            case (tecla)
              4'hA, 4'hB: begin
                alu_start <= 1'b1;
                subtract  <= tecla[0];
                key       <= 1'b0;
                state     <= ALU_WAIT;
              end
              4'hC: begin
                if (addr_bad) begin
                  state <= ERR;
                end else begin
                  regadress <= stack[0][ADDR_W-1:0];
                  regstore  <= stack[1];
                  regwrite  <= 1'b1;
                  // Holding key low for the write cycle keeps alu_start off the next cycle.
                  key       <= 1'b0;
                  lift      <= 1'b1;
                  state     <= IDLE;
                end
              end
              4'hD: begin
                if (addr_bad) begin
                  state <= ERR;
                end else begin
                  regadress <= stack[0][ADDR_W-1:0];
                  key       <= 1'b0;
                  state     <= LOAD_WAIT;
                end
              end
              4'hE: begin
                for (int i = DEPTH-1; i > 0; i--) stack[i] <= stack[i-1];
                lift  <= 1'b0;
                state <= IDLE;
              end
              4'hF: begin
                stack[0] <= '0;
                lift     <= 1'b0;
                state    <= IDLE;
              end
              default: begin
                if (state == IDLE) begin
                  if (lift) begin
                    for (int i = DEPTH-1; i > 0; i--) stack[i] <= stack[i-1];
                  end
                  stack[0] <= WIDTH'(tecla);
                  state    <= ENTRY;
                end else if (entry_val > {4'b0, MAXV}) begin
                  state <= ERR;
                end else begin
                  stack[0] <= entry_val[WIDTH-1:0];
                end
              end
            endcase
          end
        end
        ALU_WAIT: begin
          if (ready) begin
            subtract <= 1'b0;
            if (overflow) begin
              state <= ERR;
            end else begin
              // Drop Y into the result; the bottom entry is duplicated upward.
              stack[0] <= calcresult;
              for (int i = 1; i < DEPTH-1; i++) stack[i] <= stack[i+1];
              lift  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            key <= 1'b0;
          end
        end
        LOAD_WAIT: begin
          stack[0] <= regload;
          lift     <= 1'b1;
          state    <= IDLE;
        end
        ERR: begin
          if (accept && tecla == 4'hF) begin
            stack[0] <= '0;
            lift     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_fsm.sv
// Directed bench for rpn_stack_fsm: vector table for entry/error/clear plus hand sequences
// for ALU, store/load, reset abort and a DEPTH=2 build fed the same stimulus.
module tb_rpn_stack_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] tecla = '0;
  logic       tecla_valid = 1'b0;
  logic [7:0] calcresult = '0;
  logic       overflow = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] regload = 8'd7;

  logic [3:0] regadress, regadress_2;
  logic [7:0] regstore, regstore_2, A, A_2, B, B_2;
  logic       regwrite, regwrite_2, alu_start, alu_start_2, subtract, subtract_2;
  logic       ok, ok_2, key, key_2;

  rpn_stack_fsm #(.WIDTH(8), .DEPTH(4), .NREGS(10), .ADDR_W(4)) u4 (
    .clk(clk), .reset(reset), .tecla(tecla), .tecla_valid(tecla_valid),
    .calcresult(calcresult), .overflow(overflow), .ready(ready), .regload(regload),
    .regadress(regadress), .regstore(regstore), .regwrite(regwrite),
    .alu_start(alu_start), .subtract(subtract), .A(A), .B(B), .ok(ok), .key(key));

  rpn_stack_fsm #(.WIDTH(8), .DEPTH(2), .NREGS(10), .ADDR_W(4)) u2 (
    .clk(clk), .reset(reset), .tecla(tecla), .tecla_valid(tecla_valid),
    .calcresult(calcresult), .overflow(overflow), .ready(ready), .regload(regload),
    .regadress(regadress_2), .regstore(regstore_2), .regwrite(regwrite_2),
    .alu_start(alu_start_2), .subtract(subtract_2), .A(A_2), .B(B_2), .ok(ok_2), .key(key_2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_rw = 0;
  int viol = 0;
  logic prev_start = 1'b0;
  logic prev_rw = 1'b0;

  // Reads pre-edge register values, so each count reflects the cycle just ended.
  always @(posedge clk) begin
    if (alu_start) n_start++;
    if (regwrite) n_rw++;
    if (regwrite && alu_start) viol++;
    if ((regwrite && prev_start) || (alu_start && prev_rw)) viol++;
    prev_start = alu_start;
    prev_rw    = regwrite;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    tecla       = c;
    tecla_valid = 1'b1;
    @(negedge clk);
    tecla_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic alu_ready(input logic [7:0] res, input logic ovf);
    @(negedge clk);
    calcresult = res;
    overflow   = ovf;
    ready      = 1'b1;
    @(negedge clk);
    ready    = 1'b0;
    overflow = 1'b0;
  endtask

  typedef struct {
    logic [3:0] code;
    logic [7:0] exp_b;
    logic [7:0] exp_a;
    logic       exp_ok;
  } vec_t;

  vec_t vecs [11];
  int   s0;

  initial begin
    vecs[0]  = '{4'h1, 8'd1,   8'd0,   1'b1};
    vecs[1]  = '{4'h2, 8'd12,  8'd0,   1'b1};
    vecs[2]  = '{4'h3, 8'd123, 8'd0,   1'b1};
    vecs[3]  = '{4'h9, 8'h7F,  8'h7F,  1'b0};
    vecs[4]  = '{4'h5, 8'h7F,  8'h7F,  1'b0};
    vecs[5]  = '{4'hF, 8'd0,   8'd0,   1'b1};
    vecs[6]  = '{4'h4, 8'd4,   8'd0,   1'b1};
    vecs[7]  = '{4'hE, 8'd4,   8'd4,   1'b1};
    vecs[8]  = '{4'h6, 8'd6,   8'd4,   1'b1};
    vecs[9]  = '{4'hE, 8'd6,   8'd6,   1'b1};
    vecs[10] = '{4'hF, 8'd0,   8'd6,   1'b1};

    do_reset();
    @(negedge clk);
    chk("rst_ok", ok, 1);
    chk("rst_key", key, 1);
    chk("rst_regwrite", regwrite, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_subtract", subtract, 0);
    chk("rst_regadress", regadress, 0);
    chk("rst_regstore", regstore, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);

    for (int i = 0; i < 11; i++) begin
      press(vecs[i].code);
      chk($sformatf("vec%0d_B", i), B, vecs[i].exp_b);
      chk($sformatf("vec%0d_A", i), A, vecs[i].exp_a);
      chk($sformatf("vec%0d_ok", i), ok, vecs[i].exp_ok);
    end

    // Add: 5 E 3 A, keys during ALU_WAIT are dropped
    do_reset();
    s0 = n_start;
    press(4'h5); press(4'hE); press(4'h3); press(4'hA);
    chk("add_start", alu_start, 1);
    chk("add_sub", subtract, 0);
    chk("add_key_busy", key, 0);
    chk("add_A_before", A, 5);
    press(4'h7);
    chk("add_start_pulse", alu_start, 0);
    chk("busy_B", B, 3);
    chk("busy_A", A, 5);
    alu_ready(8'd8, 1'b0);
    chk("add_B", B, 8);
    chk("add_A_after", A, 0);
    chk("add_key_back", key, 1);
    chk("add_ok", ok, 1);
    @(negedge clk);
    chk("add_start_count", n_start - s0, 1);

    // Sub with overflow -> ERR, then clear
    do_reset();
    press(4'h9); press(4'hE); press(4'h4); press(4'hB);
    chk("sub_mode", subtract, 1);
    @(negedge clk);
    chk("sub_mode_held", subtract, 1);
    alu_ready(8'd0, 1'b1);
    chk("ovf_ok", ok, 0);
    chk("ovf_B", B, 8'h7F);
    press(4'hF);
    chk("clr_ok", ok, 1);
    chk("clr_B", B, 0);
    chk("clr_A", A, 9);

    // Store then load
    do_reset();
    s0 = n_rw;
    press(4'h7); press(4'hE); press(4'h2); press(4'hC);
    chk("st_regwrite", regwrite, 1);
    chk("st_regadress", regadress, 2);
    chk("st_regstore", regstore, 7);
    @(negedge clk);
    chk("st_regwrite_off", regwrite, 0);
    chk("st_rw_count", n_rw - s0, 1);
    press(4'h2);
    press(4'hD);
    chk("ld_regadress", regadress, 2);
    chk("ld_key_busy", key, 0);
    @(negedge clk);
    chk("ld_B", B, 7);
    chk("ld_A", A, 2);

    // Reset during ALU_WAIT, then a stray ready
    do_reset();
    press(4'h3); press(4'hE); press(4'h4); press(4'hA);
    do_reset();
    alu_ready(8'd55, 1'b0);
    chk("abort_B", B, 0);
    chk("abort_A", A, 0);
    chk("abort_ok", ok, 1);

    // Bad store address
    do_reset();
    s0 = n_rw;
    press(4'h1); press(4'h2); press(4'hC);
    chk("badaddr_ok", ok, 0);
    @(negedge clk);
    chk("badaddr_rw", n_rw - s0, 0);

    // DEPTH=2 build loses the old bottom entry on push
    do_reset();
    press(4'h1); press(4'hE); press(4'h2); press(4'hE);
    chk("d4_A_push", A, 2);
    chk("d2_A_push", A_2, 2);
    press(4'hA);
    alu_ready(8'd4, 1'b0);
    chk("d4_B_add", B, 4);
    chk("d4_A_add", A, 1);
    chk("d2_B_add", B_2, 4);
    chk("d2_A_add", A_2, 2);

    repeat (2) @(negedge clk);
    chk("rw_start_spacing", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
